// File: rtl/serial_adder_if.sv
// serial_adder_if: request/response bundle for serial_adder
// master drives start/a/b/cin and observes busy/done/sum/cout;
// slave is the adder. ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus registered carry
// ports: clk, rst (async, active-high), bus (serial_adder_if.slave:
// start/a/b/cin in; busy/done/sum/cout out; ovf out with SERIAL_ADDER_OVF_EN)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s, co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif
  assign s  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign co = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == RUN) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      s_sh_d = {s, s_sh_q[WIDTH-1:1]};
      c_d    = co;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        sum_d   = s_sh_d;
        cout_d  = co;
        state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
        // c_q is the carry into the MSB on the final step
        ovf_d   = c_q ^ co;
`endif
      end
    end else if (bus.start) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      c_d     = bus.cin;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder with directed vectors
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];
  int done_cyc[$];
  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got sum=%h cout=%b required no done", bus.sum, bus.cout);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({bus.cout, bus.sum} !== e[8:0]) begin
          errors++;
          $display("FAIL result got cout=%b sum=%h required cout=%b sum=%h", bus.cout, bus.sum, e[8], e[7:0]);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (bus.ovf !== e[9]) begin
          errors++;
          $display("FAIL ovf got %b required %b", bus.ovf, e[9]);
        end
`endif
      end
    end
  end
  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [9:0] e);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.a = 8'hxx; bus.b = 8'hxx; bus.cin = 1'bx;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) return;
      if (bus.busy) n++;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout got no done required done within 40 cycles");
  endtask
  int n;
  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 9'(bus.busy), 9'd0);
    chk("reset_done", 9'(bus.done), 9'd0);
    chk("reset_sum", 9'(bus.sum), 9'd0);
    chk("reset_cout", 9'(bus.cout), 9'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset_ovf", 9'(bus.ovf), 9'd0);
`endif
    rst = 1'b0;
    issue(8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00});
    wait_done(n); chk("busy_len_zero", 9'(n), 9'd8);
    issue(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
    wait_done(n); chk("busy_len_ff01", 9'(n), 9'd8);
    issue(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
    wait_done(n); chk("busy_len_7f01", 9'(n), 9'd8);
    issue(8'hA5, 8'h5A, 1'b1, {1'b0, 1'b1, 8'h00});
    wait_done(n); chk("busy_len_a55a", 9'(n), 9'd8);
    issue(8'h03, 8'h04, 1'b0, {1'b0, 1'b0, 8'h07});
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    repeat (12) @(negedge clk);
    chk("held_sum", {bus.cout, bus.sum}, 9'h007);
    chk("idle_after_ignore", 9'(bus.busy), 9'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", 9'(bus.busy), 9'd0);
    chk("rst_done", 9'(bus.done), 9'd0);
    chk("rst_sum", 9'(bus.sum), 9'd0);
    chk("rst_cout", 9'(bus.cout), 9'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46});
    wait_done(n); chk("busy_len_after_rst", 9'(n), 9'd8);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'h33});
    @(negedge clk);
    wait_done(n); chk("busy_len_b2b1", 9'(n), 9'd8);
    bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'h30});
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n); chk("busy_len_b2b2", 9'(n), 9'd8);
    @(negedge clk);
    chk("b2b_spacing", (done_cyc.size() >= 2) ? 9'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]) : 9'h1FF, 9'd9);
    chk("done_total", 9'(done_cyc.size()), 9'd8);
    chk("queue_empty", 9'(exp_q.size()), 9'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
